// File: rtl/vrased_rst_ctrl.sv
// Kill/reset sequencer for the VRASED monitors: holds the MCU in reset after any
// violation until the hold window expires and the CPU fetches the reset handler.
module vrased_rst_ctrl #(
    parameter int          N_MON         = 4,
    parameter int          MIN_HOLD      = 8,
    parameter int          CNT_W         = 8,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
    parameter logic [15:0] SMEM_BASE     = 16'hA000,
    parameter logic [15:0] SMEM_SIZE     = 16'h4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      pc,
    input  logic [N_MON-1:0] viol,
    input  logic             cause_clr,
    output logic             system_rst,
    output logic [N_MON-1:0] rst_cause,
    output logic [CNT_W-1:0] kill_cnt,
    output logic [1:0]       state_o
);

    localparam int              HOLD_W    = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(MIN_HOLD - 1);
    // Last valid word address of secure ROM, computed in 17 bits so it cannot wrap.
    localparam logic [16:0]     SROM_LAST = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd2;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HOLD = 2'b01,
        WAIT = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t              state, state_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                sys_nxt;
    logic [N_MON-1:0]    cause_nxt;
    logic [CNT_W-1:0]    kill_nxt;
    logic                any_viol, pc_in_srom, at_handler;

    assign any_viol   = |viol;
    assign pc_in_srom = ({1'b0, pc} >= {1'b0, SMEM_BASE}) && ({1'b0, pc} <= SROM_LAST);
    assign at_handler = (pc == RESET_HANDLER);
    assign state_o    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            hold_cnt   <= '0;
            system_rst <= 1'b0;
            rst_cause  <= '0;
            kill_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            system_rst <= sys_nxt;
            rst_cause  <= cause_nxt;
            kill_cnt   <= kill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:  if (any_viol) state_nxt = HOLD;
            HOLD: if (hold_cnt == '0) state_nxt = WAIT;
            WAIT: begin
                if (any_viol)        state_nxt = HOLD;
                else if (at_handler) state_nxt = RUN;
            end
            default: state_nxt = WAIT;
        endcase
    end

    // A violation seen in WAIT belongs to the same kill, so only RUN bumps the counter.
    always_comb begin
        sys_nxt   = 1'b1;
        cause_nxt = rst_cause;
        kill_nxt  = kill_cnt;
        hold_nxt  = hold_cnt;
        case (state)
            RUN: begin
                if (any_viol) begin
                    cause_nxt = viol;
                    hold_nxt  = HOLD_INIT;
                    if (kill_cnt != '1) kill_nxt = kill_cnt + CNT_W'(1);
                end else begin
                    sys_nxt = 1'b0;
                    if (cause_clr && pc_in_srom) cause_nxt = '0;
                end
            end
            HOLD: begin
                cause_nxt = rst_cause | viol;
                if (hold_cnt != '0) hold_nxt = hold_cnt - HOLD_W'(1);
            end
            WAIT: begin
                if (any_viol) begin
                    cause_nxt = rst_cause | viol;
                    hold_nxt  = HOLD_INIT;
                end else if (at_handler) begin
                    sys_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vrased_rst_ctrl.sv
// Bench for vrased_rst_ctrl: directed kill scenarios plus random traffic,
// compared every cycle against a timestamp-based model of the kill sequence.
module tb_vrased_rst_ctrl;

    localparam int N_MON    = 4;
    localparam int MIN_HOLD = 8;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      pc;
    logic [N_MON-1:0] viol;
    logic             cause_clr;
    logic             system_rst;
    logic [N_MON-1:0] rst_cause;
    logic [CNT_W-1:0] kill_cnt;
    logic [1:0]       state_o;

    int n_asrt = 0;
    int n_fail = 0;

    // model: a kill is a time span; release is allowed once more than MIN_HOLD
    // edges have passed since the violation that (re)started the hold window
    bit               m_kill;
    int               m_start;
    logic [N_MON-1:0] m_cause;
    int               m_cnt;
    int               cyc;

    vrased_rst_ctrl #(
        .N_MON(N_MON), .MIN_HOLD(MIN_HOLD), .CNT_W(CNT_W),
        .RESET_HANDLER(16'hFFFE), .SMEM_BASE(16'hA000), .SMEM_SIZE(16'h4000)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .viol(viol), .cause_clr(cause_clr),
        .system_rst(system_rst), .rst_cause(rst_cause), .kill_cnt(kill_cnt),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_kill  = 1'b0;
        m_start = 0;
        m_cause = '0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic [N_MON-1:0] v, input logic [15:0] p, input logic c);
        if (!m_kill) begin
            if (v != 0) begin
                m_kill  = 1'b1;
                m_start = cyc;
                m_cause = v;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else if (c && p >= 16'hA000 && p <= 16'hDFFE) begin
                m_cause = '0;
            end
        end else if (cyc - m_start > MIN_HOLD) begin
            if (v != 0) begin
                m_start = cyc;
                m_cause = m_cause | v;
            end else if (p == 16'hFFFE) begin
                m_kill = 1'b0;
            end
        end else begin
            m_cause = m_cause | v;
        end
    endtask

    function automatic logic [1:0] model_state();
        if (!m_kill) return 2'b00;
        return (cyc - m_start >= MIN_HOLD) ? 2'b10 : 2'b01;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".system_rst"}, 32'(system_rst), 32'(m_kill));
        check({tag, ".rst_cause"},  32'(rst_cause),  32'(m_cause));
        check({tag, ".kill_cnt"},   32'(kill_cnt),   32'(m_cnt));
        check({tag, ".state"},      32'(state_o),    32'(model_state()));
    endtask

    task automatic step(input logic [N_MON-1:0] v, input logic [15:0] p, input logic c,
                        input string tag);
        @(negedge clk);
        viol      = v;
        pc        = p;
        cause_clr = c;
        @(posedge clk);
        cyc++;
        model_edge(v, p, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        int hi_cnt;
        rst = 1'b1; pc = 16'h0000; viol = '0; cause_clr = 1'b0;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // single-cycle violation; count how long system_rst stays high
        step(4'b0001, 16'hFFFE, 1'b0, "t1.kill");
        hi_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            step(4'b0000, 16'hFFFE, 1'b0, "t1.run");
            if (system_rst) hi_cnt++;
        end
        check("t1.kill_len", 32'(hi_cnt), 32'(MIN_HOLD + 1));
        check("t1.kill_cnt", 32'(kill_cnt), 32'd1);
        check("t1.cause", 32'(rst_cause), 32'h1);

        // stuck in WAIT, re-kill from WAIT, then release
        step(4'b0010, 16'h0000, 1'b0, "t2.kill");
        for (int i = 0; i < 30; i++) step(4'b0000, 16'h0000, 1'b0, "t2.wait");
        check("t2.in_wait", 32'(state_o), 32'h2);
        step(4'b0100, 16'h0000, 1'b0, "t3.rekill");
        for (int i = 0; i < 12; i++) step(4'b0000, 16'hFFFE * (i / 11), 1'b0, "t3.hold");
        check("t3.cause", 32'(rst_cause), 32'h6);
        check("t3.kill_cnt", 32'(kill_cnt), 32'd2);
        for (int i = 0; i < 3; i++) step(4'b0000, 16'hFFFE, 1'b0, "t2.release");
        check("t2.released", 32'(system_rst), 32'h0);

        // cause_clr qualification
        step(4'b0001, 16'hFFFE, 1'b0, "t4.kill");
        for (int i = 0; i < 12; i++) step(4'b0000, 16'hFFFE, 1'b0, "t4.run");
        step(4'b0000, 16'h1234, 1'b1, "t4.clr_outside");
        check("t4.clr_outside", 32'(rst_cause), 32'h1);
        step(4'b0000, 16'hA010, 1'b1, "t4.clr_inside");
        check("t4.clr_inside", 32'(rst_cause), 32'h0);
        step(4'b1000, 16'hA010, 1'b1, "t4.clr_vs_viol");
        check("t4.clr_vs_viol", 32'(rst_cause), 32'h8);
        step(4'b0000, 16'hA010, 1'b1, "t4.clr_in_hold");
        check("t4.clr_in_hold", 32'(rst_cause), 32'h8);
        for (int i = 0; i < 12; i++) step(4'b0000, 16'hFFFE, 1'b0, "t4.release");

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            logic [N_MON-1:0] v;
            logic [15:0]      p;
            int               r;
            v = ($urandom_range(0, 11) == 0) ? N_MON'($urandom_range(1, 15)) : '0;
            r = $urandom_range(0, 3);
            p = (r == 0) ? 16'hFFFE : (r == 1) ? 16'(16'hA000 + 2 * $urandom_range(0, 8191)) :
                (r == 2) ? 16'hDFFF + 16'($urandom_range(0, 1)) : 16'($urandom);
            step(v, p, 1'($urandom_range(0, 1)), "rand");
        end

        // saturation of the kill counter
        for (int k = 0; k < 300; k++) begin
            step(4'b0001, 16'hFFFE, 1'b0, "t5.kill");
            for (int i = 0; i < MIN_HOLD + 1; i++) step(4'b0000, 16'hFFFE, 1'b0, "t5.run");
        end
        check("t5.saturated", 32'(kill_cnt), 32'(CNT_MAX));

        // asynchronous reset in the middle of HOLD
        step(4'b0100, 16'hFFFE, 1'b0, "t5.kill2");
        step(4'b0000, 16'hFFFE, 1'b0, "t5.hold");
        check("t5.in_hold", 32'(state_o), 32'h1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("t5.async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(4'b0000, 16'hFFFE, 1'b0, "t5.after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
